// File: rtl/mii_frame_checker.sv
// MII receive-side frame checker: parses START..TERMINATE frames, streams the payload, reports status.
// Define MII_CHECKER_CRC_EN to check the FCS as a real CRC-32 instead of the fixed FCS_CODE pattern.
module mii_frame_checker #(
   parameter int         PREAMBLE_BYTES = 6,
   parameter int         DST_ADDR_BYTES = 6,
   parameter int         SRC_ADDR_BYTES = 6,
   parameter int         LEN_TYP_BYTES  = 2,
   parameter int         DATA_MIN       = 46,
   parameter int         DATA_MAX       = 1500,
   parameter logic [7:0] IDLE_CODE      = 8'h07,
   parameter logic [7:0] START_CODE     = 8'hFB,
   parameter logic [7:0] TERMINATE_CODE = 8'hFD,
   parameter logic [7:0] PREAMBLE_CODE  = 8'h55,
   parameter logic [7:0] SFD_CODE       = 8'hD5,
   parameter logic [7:0] DST_ADDR_CODE  = 8'h01,
   parameter logic [7:0] SRC_ADDR_CODE  = 8'h02,
   parameter logic [7:0] LEN_TYP_CODE   = 8'h03,
   parameter logic [7:0] FCS_CODE       = 8'h04
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [7:0]  i_rx_data,
   input  logic [7:0]  i_rx_ctrl,
   output logic [7:0]  o_data,
   output logic        o_data_valid,
   output logic        o_data_last,
   output logic        o_frame_done,
   output logic        o_frame_ok,
   output logic [5:0]  o_err,
   output logic [10:0] o_payload_len,
   output logic [15:0] o_good_frames,
   output logic [15:0] o_bad_frames
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_PREAMBLE, ST_SFD, ST_HEADER, ST_PAYLOAD, ST_DROP
   } state_t;

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [7:0]  HDR_LAST = 8'(DST_ADDR_BYTES + SRC_ADDR_BYTES + LEN_TYP_BYTES - 1);
   localparam logic [7:0]  DST_END  = 8'(DST_ADDR_BYTES);
   localparam logic [7:0]  SRC_END  = 8'(DST_ADDR_BYTES + SRC_ADDR_BYTES);
   localparam logic [10:0] LEN_MIN  = 11'(DATA_MIN);
   localparam logic [10:0] LEN_MAX  = 11'(DATA_MAX);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [5:0]      err_q, err_d;
   logic [2:0]      fill_q, fill_d;
   logic [4:0][7:0] dline_q, dline_d;
   logic [10:0]     len_q, len_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d, last_q, last_d, done_q, done_d, ok_q, ok_d;
   logic [5:0]      oerr_q, oerr_d;
   logic [10:0]     olen_q, olen_d;
   logic [15:0]     good_q, good_d, bad_q, bad_d;

   logic            is_ctrl, report, fcs_bad;
   logic [5:0]      rep_err;
   logic [10:0]     rep_len, fin_len;
   logic [7:0]      hdr_exp;
   logic            unused_ctrl;

   assign is_ctrl     = i_rx_ctrl[0];
   assign unused_ctrl = ^i_rx_ctrl[7:1];

`ifdef MII_CHECKER_CRC_EN
   logic [31:0] crc_q, crc_d, crc_fin;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fill_d  = fill_q;
      dline_d = dline_q;
      len_d   = len_q;
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      report  = 1'b0;
      rep_err = err_q;
      rep_len = len_q;
      // at TERMINATE the oldest delay-line entry is the final payload byte, the rest is FCS
      fin_len = len_q + {10'd0, (fill_q == 3'd5)};
      hdr_exp = (cnt_q < DST_END) ? DST_ADDR_CODE :
                (cnt_q < SRC_END) ? SRC_ADDR_CODE : LEN_TYP_CODE;
`ifdef MII_CHECKER_CRC_EN
      crc_d   = crc_q;
      crc_fin = crc32_byte(crc_q, dline_q[4]);
      fcs_bad = (fill_q != 3'd5) ||
                (~crc_fin != {dline_q[0], dline_q[1], dline_q[2], dline_q[3]});
`else
      fcs_bad = (fill_q != 3'd5) ||
                (dline_q[3] != FCS_CODE) || (dline_q[2] != FCS_CODE) ||
                (dline_q[1] != FCS_CODE) || (dline_q[0] != FCS_CODE);
`endif

      case (state_q)
         ST_IDLE: begin
            if (is_ctrl && i_rx_data == START_CODE) begin
               state_d = ST_PREAMBLE;
               cnt_d   = '0;
               err_d   = '0;
               len_d   = '0;
               fill_d  = '0;
            end
         end
         ST_DROP: begin
            if (is_ctrl && (i_rx_data == TERMINATE_CODE || i_rx_data == IDLE_CODE)) begin
               report  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (is_ctrl) begin
               if (i_rx_data == TERMINATE_CODE) begin
                  report  = 1'b1;
                  state_d = ST_IDLE;
                  if (state_q == ST_PAYLOAD) begin
                     rep_len = fin_len;
                     rep_err = err_q | {1'b0, fcs_bad, 1'b0, (fin_len < LEN_MIN), 2'b00};
                     if (fill_q == 3'd5) begin
                        data_d  = dline_q[4];
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                     end
                  end else begin
                     rep_err = err_q | 6'b100000;
                  end
               end else if (i_rx_data == START_CODE) begin
                  // close the current frame as bad and start parsing the new one at once
                  report  = 1'b1;
                  rep_err = err_q | 6'b100000;
                  state_d = ST_PREAMBLE;
                  cnt_d   = '0;
                  err_d   = '0;
                  len_d   = '0;
                  fill_d  = '0;
               end else begin
                  err_d   = err_q | 6'b100000;
                  state_d = ST_DROP;
               end
            end else begin
               case (state_q)
                  ST_PREAMBLE: begin
                     if (i_rx_data != PREAMBLE_CODE) begin
                        err_d   = err_q | 6'b000001;
                        state_d = ST_DROP;
                     end else if (cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                     end else begin
                        cnt_d = cnt_q + 8'd1;
                     end
                  end
                  ST_SFD: begin
                     if (i_rx_data == SFD_CODE) begin
                        state_d = ST_HEADER;
                        cnt_d   = '0;
`ifdef MII_CHECKER_CRC_EN
                        crc_d   = '1;
`endif
                     end else begin
                        err_d   = err_q | 6'b000001;
                        state_d = ST_DROP;
                     end
                  end
                  ST_HEADER: begin
                     if (i_rx_data != hdr_exp)
                        err_d = err_q | 6'b000010;
`ifdef MII_CHECKER_CRC_EN
                     crc_d = crc32_byte(crc_q, i_rx_data);
`endif
                     if (cnt_q == HDR_LAST) begin
                        state_d = ST_PAYLOAD;
                        fill_d  = '0;
                        len_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 8'd1;
                     end
                  end
                  ST_PAYLOAD: begin
                     dline_d = {dline_q[3:0], i_rx_data};
                     if (fill_q != 3'd5) begin
                        fill_d = fill_q + 3'd1;
                     end else if (len_q == LEN_MAX) begin
                        err_d   = err_q | 6'b001000;
                        state_d = ST_DROP;
                     end else begin
                        data_d  = dline_q[4];
                        valid_d = 1'b1;
                        len_d   = len_q + 11'd1;
`ifdef MII_CHECKER_CRC_EN
                        crc_d   = crc32_byte(crc_q, dline_q[4]);
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase

      done_d = report;
      ok_d   = report && (rep_err == '0);
      oerr_d = report ? rep_err : oerr_q;
      olen_d = report ? rep_len : olen_q;
      good_d = good_q;
      bad_d  = bad_q;
      if (report && rep_err == '0 && good_q != '1) good_d = good_q + 16'd1;
      if (report && rep_err != '0 && bad_q != '1)  bad_d  = bad_q + 16'd1;
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         fill_q  <= '0;
         dline_q <= '0;
         len_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         oerr_q  <= '0;
         olen_q  <= '0;
         good_q  <= '0;
         bad_q   <= '0;
`ifdef MII_CHECKER_CRC_EN
         crc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fill_q  <= fill_d;
         dline_q <= dline_d;
         len_q   <= len_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         oerr_q  <= oerr_d;
         olen_q  <= olen_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
`ifdef MII_CHECKER_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

   assign o_data        = data_q;
   assign o_data_valid  = valid_q;
   assign o_data_last   = last_q;
   assign o_frame_done  = done_q;
   assign o_frame_ok    = ok_q;
   assign o_err         = oerr_q;
   assign o_payload_len = olen_q;
   assign o_good_frames = good_q;
   assign o_bad_frames  = bad_q;

endmodule

// File: tb/tb_mii_frame_checker.sv
// Scoreboard bench for mii_frame_checker (default build, fixed FCS pattern).
module tb_mii_frame_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data, rx_ctrl;
   logic [7:0]  o_data;
   logic        o_data_valid, o_data_last, o_frame_done, o_frame_ok;
   logic [5:0]  o_err;
   logic [10:0] o_payload_len;
   logic [15:0] o_good_frames, o_bad_frames;

   always #5 clk = ~clk;

   mii_frame_checker dut (
      .clk           (clk),
      .i_rst         (rst),
      .i_rx_data     (rx_data),
      .i_rx_ctrl     (rx_ctrl),
      .o_data        (o_data),
      .o_data_valid  (o_data_valid),
      .o_data_last   (o_data_last),
      .o_frame_done  (o_frame_done),
      .o_frame_ok    (o_frame_ok),
      .o_err         (o_err),
      .o_payload_len (o_payload_len),
      .o_good_frames (o_good_frames),
      .o_bad_frames  (o_bad_frames)
   );

   typedef struct {
      logic        ok;
      logic [5:0]  err;
      logic [10:0] len;
      logic [15:0] good;
      logic [15:0] bad;
   } rep_t;

   rep_t       obs_rep[$];
   logic [7:0] exp_byte[$];
   logic       exp_last[$];
   int         n_chk = 0, n_fail = 0;
   int         exp_good = 0, exp_bad = 0;
   logic [7:0] mon_b;
   logic       mon_l;

   // payload beats are checked against the expected queue as they leave the DUT
   always @(negedge clk) begin
      if (!rst) begin
         if (o_data_valid) begin
            n_chk++;
            if (exp_byte.size() == 0) begin
               n_fail++;
               $display("FAIL beat_unexpected: got data=%h last=%0b required no beat", o_data, o_data_last);
            end else begin
               mon_b = exp_byte.pop_front();
               mon_l = exp_last.pop_front();
               if ({o_data_last, o_data} !== {mon_l, mon_b}) begin
                  n_fail++;
                  $display("FAIL beat: got data=%h last=%0b required data=%h last=%0b",
                           o_data, o_data_last, mon_b, mon_l);
               end
            end
         end
         if (o_frame_done)
            obs_rep.push_back('{o_frame_ok, o_err, o_payload_len, o_good_frames, o_bad_frames});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic c, input logic [7:0] d);
      @(negedge clk);
      rx_ctrl = {7'($urandom), c};
      rx_data = d;
   endtask

   // mode 0: FCS + TERMINATE, mode 1: IDLE_CODE right after payload, mode 2: stop after payload
   task automatic drive_frame(input int npay, input int bad_pre, input int bad_fcs,
                              input int mode, input int seed, input int gap);
      send(1'b1, 8'hFB);
      for (int i = 0; i < 6; i++) send(1'b0, (i == bad_pre) ? 8'h54 : 8'h55);
      send(1'b0, 8'hD5);
      for (int i = 0; i < 14; i++) send(1'b0, (i < 6) ? 8'h01 : (i < 12) ? 8'h02 : 8'h03);
      for (int i = 0; i < npay; i++) begin
         if (bad_pre < 0 && (mode == 0 || (i < npay - 5 && i < 1500))) begin
            exp_byte.push_back(8'(i + seed));
            exp_last.push_back(mode == 0 && i == npay - 1);
         end
         send(1'b0, 8'(i + seed));
      end
      if (mode == 0) begin
         for (int i = 0; i < 4; i++) send(1'b0, (i == bad_fcs) ? 8'h05 : 8'h04);
         send(1'b1, 8'hFD);
      end else if (mode == 1) begin
         send(1'b1, 8'h07);
      end
      for (int i = 0; i < gap; i++) send(1'b1, 8'h07);
   endtask

   task automatic wait_rep(output bit got, output rep_t r);
      got = 1'b0;
      r   = '{1'b0, 6'd0, 11'd0, 16'd0, 16'd0};
      for (int k = 0; k < 3000; k++) begin
         if (obs_rep.size() > 0) begin
            got = 1'b1;
            r   = obs_rep.pop_front();
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx_ctrl = 8'h01;
      rx_data = 8'h07;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({o_data, o_data_valid, o_data_last, o_frame_done, o_frame_ok, o_err,
           o_payload_len, o_good_frames, o_bad_frames} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%0b l=%0b done=%0b ok=%0b err=%b len=%0d good=%0d bad=%0d required all zero",
                  o_data, o_data_valid, o_data_last, o_frame_done, o_frame_ok, o_err,
                  o_payload_len, o_good_frames, o_bad_frames);
      end
      rst = 1'b0;
      send(1'b0, 8'hFB);
      send(1'b1, 8'hFD);
      send(1'b1, 8'h07);
      repeat (4) send(1'b1, 8'h07);
      n_chk++;
      if (obs_rep.size() != 0) begin
         n_fail++;
         $display("FAIL idle_no_frame: got %0d frame reports required 0", obs_rep.size());
      end
   endtask

   task automatic test_nominal(input int seed);
      bit got;
      rep_t r;
      drive_frame(46, -1, -1, 0, seed, 3);
      exp_good++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL nominal_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len} !== {1'b1, 6'b000000, 11'd46}) begin
            n_fail++;
            $display("FAIL nominal_status: got ok=%0b err=%b len=%0d required ok=1 err=000000 len=46",
                     r.ok, r.err, r.len);
         end
         n_chk++;
         if ({r.good, r.bad} !== {16'(exp_good), 16'(exp_bad)}) begin
            n_fail++;
            $display("FAIL nominal_counters: got good=%0d bad=%0d required good=%0d bad=%0d",
                     r.good, r.bad, exp_good, exp_bad);
         end
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL nominal_beats: got %0d beats missing required 0", exp_byte.size());
      end
   endtask

   task automatic test_bad_preamble;
      bit got;
      rep_t r;
      drive_frame(46, 2, -1, 0, 0, 3);
      exp_bad++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL bad_pre_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len, r.good, r.bad} !==
             {1'b0, 6'b000001, 11'd0, 16'(exp_good), 16'(exp_bad)}) begin
            n_fail++;
            $display("FAIL bad_pre_status: got ok=%0b err=%b len=%0d good=%0d bad=%0d required ok=0 err=000001 len=0 good=%0d bad=%0d",
                     r.ok, r.err, r.len, r.good, r.bad, exp_good, exp_bad);
         end
      end
      test_nominal(7);
   endtask

   task automatic test_short_bad_fcs;
      bit got;
      rep_t r;
      drive_frame(40, -1, 1, 0, 16, 3);
      exp_bad++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL short_fcs_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len, r.bad} !== {1'b0, 6'b010100, 11'd40, 16'(exp_bad)}) begin
            n_fail++;
            $display("FAIL short_fcs_status: got ok=%0b err=%b len=%0d bad=%0d required ok=0 err=010100 len=40 bad=%0d",
                     r.ok, r.err, r.len, r.bad, exp_bad);
         end
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL short_fcs_beats: got %0d beats missing required 0", exp_byte.size());
      end
   endtask

   task automatic test_min_boundary;
      bit got;
      rep_t r;
      drive_frame(45, -1, -1, 0, 100, 3);
      exp_bad++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL min_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len} !== {1'b0, 6'b000100, 11'd45}) begin
            n_fail++;
            $display("FAIL min_status: got ok=%0b err=%b len=%0d required ok=0 err=000100 len=45",
                     r.ok, r.err, r.len);
         end
      end
   endtask

   task automatic test_oversize;
      bit got;
      rep_t r;
      // 1506 bytes: the 1501st beat would leave the 5-byte delay line on the 1506th byte
      drive_frame(1506, -1, -1, 1, 0, 2);
      exp_bad++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL oversize_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len, r.bad} !== {1'b0, 6'b001000, 11'd1500, 16'(exp_bad)}) begin
            n_fail++;
            $display("FAIL oversize_status: got ok=%0b err=%b len=%0d bad=%0d required ok=0 err=001000 len=1500 bad=%0d",
                     r.ok, r.err, r.len, r.bad, exp_bad);
         end
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL oversize_beats: got %0d beats missing required 0", exp_byte.size());
      end
   endtask

   task automatic test_start_in_payload;
      bit got;
      rep_t r;
      drive_frame(20, -1, -1, 2, 0, 0);
      drive_frame(46, -1, -1, 0, 5, 3);
      exp_bad++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL restart_first_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len, r.bad} !== {1'b0, 6'b100000, 11'd15, 16'(exp_bad)}) begin
            n_fail++;
            $display("FAIL restart_first_status: got ok=%0b err=%b len=%0d bad=%0d required ok=0 err=100000 len=15 bad=%0d",
                     r.ok, r.err, r.len, r.bad, exp_bad);
         end
      end
      exp_good++;
      wait_rep(got, r);
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL restart_second_done: got no o_frame_done required one");
      end else begin
         n_chk++;
         if ({r.ok, r.err, r.len, r.good} !== {1'b1, 6'b000000, 11'd46, 16'(exp_good)}) begin
            n_fail++;
            $display("FAIL restart_second_status: got ok=%0b err=%b len=%0d good=%0d required ok=1 err=000000 len=46 good=%0d",
                     r.ok, r.err, r.len, r.good, exp_good);
         end
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL restart_beats: got %0d beats missing required 0", exp_byte.size());
      end
   endtask

   task automatic test_back_to_back;
      bit got;
      rep_t r;
      drive_frame(50, -1, -1, 0, 3, 0);
      drive_frame(46, -1, -1, 0, 200, 3);
      for (int f = 0; f < 2; f++) begin
         exp_good++;
         wait_rep(got, r);
         n_chk++;
         if (!got) begin
            n_fail++;
            $display("FAIL b2b_done: frame %0d got no o_frame_done required one", f);
         end else begin
            n_chk++;
            if ({r.ok, r.err, r.len, r.good} !==
                {1'b1, 6'b000000, (f == 0) ? 11'd50 : 11'd46, 16'(exp_good)}) begin
               n_fail++;
               $display("FAIL b2b_status: frame %0d got ok=%0b err=%b len=%0d good=%0d required ok=1 err=000000 len=%0d good=%0d",
                        f, r.ok, r.err, r.len, r.good, (f == 0) ? 50 : 46, exp_good);
            end
         end
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_beats: got %0d beats missing required 0", exp_byte.size());
      end
   endtask

   task automatic test_reset_mid_payload;
      drive_frame(30, -1, -1, 2, 0, 0);
      @(negedge clk);
      #1 rst = 1'b1;
      rx_ctrl = 8'h01;
      rx_data = 8'h07;
      #1;
      n_chk++;
      if ({o_data, o_data_valid, o_data_last, o_frame_done, o_frame_ok, o_err,
           o_payload_len, o_good_frames, o_bad_frames} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got data=%h v=%0b done=%0b err=%b len=%0d good=%0d bad=%0d required all zero",
                  o_data, o_data_valid, o_frame_done, o_err, o_payload_len, o_good_frames, o_bad_frames);
      end
      n_chk++;
      if (exp_byte.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_beats: got %0d beats missing required 0", exp_byte.size());
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_good = 0;
      exp_bad  = 0;
      repeat (3) send(1'b1, 8'h07);
      n_chk++;
      if (obs_rep.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_no_done: got %0d frame reports required 0", obs_rep.size());
      end
      test_nominal(42);
   endtask

   initial begin
      test_reset();
      test_nominal(0);
      test_bad_preamble();
      test_short_bad_fcs();
      test_min_boundary();
      test_oversize();
      test_start_in_payload();
      test_back_to_back();
      test_reset_mid_payload();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
